// File: rtl/scoreboard.sv
// Register scoreboard: tracks outstanding writes and in-flight count,
// gating issue on RAW/WAW hazards and flagging bad retires.
//
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   issue_req/rs1/rs2/rd   : candidate instruction from decode
//   issue_writes_rd        : candidate writes rd
//   issue_grant            : candidate accepted this cycle (comb)
//   retire_valid/_rd       : one instruction completes writeback
//   retire_writes_rd       : retiring instruction wrote a register
//   flush                  : discard all tracking
//   pending_mask           : per-register outstanding write flags
//   inflight_cnt           : issued-but-unretired count
//   full, empty            : count at MAX_INFLIGHT / zero
//   err                    : sticky protocol-violation flag
module scoreboard #(
  parameter int REG_CNT        = 32,
  parameter int REG_ADDR_WIDTH = $clog2(REG_CNT),
  parameter int MAX_INFLIGHT   = 4,
  localparam int CW            = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      issue_req,
  input  logic [REG_ADDR_WIDTH-1:0] issue_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] issue_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] issue_rd,
  input  logic                      issue_writes_rd,
  output logic                      issue_grant,
  input  logic                      retire_valid,
  input  logic                      retire_writes_rd,
  input  logic [REG_ADDR_WIDTH-1:0] retire_rd,
  input  logic                      flush,
  output logic [REG_CNT-1:0]        pending_mask,
  output logic [CW-1:0]             inflight_cnt,
  output logic                      full,
  output logic                      empty,
  output logic                      err
);

  logic [REG_CNT-1:0] pend_q, pend_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               err_q, err_d;

  logic               hazard;
  logic               grant;
  logic               ret_bad;
  logic               ret_ok;
  logic [REG_CNT-1:0] one;

  assign one = {{(REG_CNT-1){1'b0}}, 1'b1};

  // Bit 0 is never set, so x0 sources/dest can never hazard.
  assign hazard = pend_q[issue_rs1]
                | pend_q[issue_rs2]
                | (issue_writes_rd & pend_q[issue_rd]);

  assign full  = (cnt_q == CW'(MAX_INFLIGHT));
  assign empty = (cnt_q == '0);

  // Decided on registered state only; a same-cycle retire
  // does not bypass into the hazard check.
  assign grant = issue_req & ~rst & ~flush & ~full & ~hazard;

  // A retire with nothing in flight, or of a register with no
  // outstanding write, is a protocol error and is dropped.
  assign ret_bad = retire_valid
                 & (empty
                    | (retire_writes_rd
                       & (retire_rd != '0)
                       & ~pend_q[retire_rd]));
  assign ret_ok  = retire_valid & ~ret_bad;

  always_comb begin
    pend_d = pend_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    if (flush) begin
      pend_d = '0;
      cnt_d  = '0;
    end else begin
      if (ret_ok && retire_writes_rd) begin
        pend_d = pend_d & ~(one << retire_rd);
      end
      if (grant && issue_writes_rd) begin
        pend_d = pend_d | (one << issue_rd);
      end
      if (grant && !ret_ok) begin
        cnt_d = cnt_q + CW'(1);
      end else if (ret_ok && !grant) begin
        cnt_d = cnt_q - CW'(1);
      end
      if (ret_bad) begin
        err_d = 1'b1;
      end
    end
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign issue_grant  = grant;
  assign pending_mask = pend_q;
  assign inflight_cnt = cnt_q;
  assign err          = err_q;

endmodule

// File: tb/tb_scoreboard.sv
// Self-checking bench for scoreboard: expected state is queued
// when stimulus is driven and compared after the clock edge.
module tb_scoreboard;

  logic        clk;
  logic        rst;
  logic        issue_req;
  logic [4:0]  issue_rs1;
  logic [4:0]  issue_rs2;
  logic [4:0]  issue_rd;
  logic        issue_writes_rd;
  logic        issue_grant;
  logic        retire_valid;
  logic        retire_writes_rd;
  logic [4:0]  retire_rd;
  logic        flush;
  logic [31:0] pending_mask;
  logic [2:0]  inflight_cnt;
  logic        full;
  logic        empty;
  logic        err;

  scoreboard dut (
    .clk              (clk),
    .rst              (rst),
    .issue_req        (issue_req),
    .issue_rs1        (issue_rs1),
    .issue_rs2        (issue_rs2),
    .issue_rd         (issue_rd),
    .issue_writes_rd  (issue_writes_rd),
    .issue_grant      (issue_grant),
    .retire_valid     (retire_valid),
    .retire_writes_rd (retire_writes_rd),
    .retire_rd        (retire_rd),
    .flush            (flush),
    .pending_mask     (pending_mask),
    .inflight_cnt     (inflight_cnt),
    .full             (full),
    .empty            (empty),
    .err              (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [37:0] v;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  int          n_run  = 0;
  int          n_fail = 0;
  logic [37:0] obs;

  assign obs = {pending_mask, inflight_cnt, err, full, empty};

  function automatic logic [37:0] mk(logic [31:0] pm,
                                     logic [2:0] c,
                                     logic er);
    return {pm, c, er, (c == 3'd4), (c == 3'd0)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst              = 1'b0;
    issue_req        = 1'b0;
    issue_rs1        = 5'd0;
    issue_rs2        = 5'd0;
    issue_rd         = 5'd0;
    issue_writes_rd  = 1'b0;
    retire_valid     = 1'b0;
    retire_writes_rd = 1'b0;
    retire_rd        = 5'd0;
    flush            = 1'b0;
  endtask

  task automatic iss(logic [4:0] r1, logic [4:0] r2,
                     logic [4:0] rd, logic w);
    issue_req       = 1'b1;
    issue_rs1       = r1;
    issue_rs2       = r2;
    issue_rd        = rd;
    issue_writes_rd = w;
  endtask

  task automatic ret(logic [4:0] rd, logic w);
    retire_valid     = 1'b1;
    retire_rd        = rd;
    retire_writes_rd = w;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    flush = 1'b1;
    iss(5'd0, 5'd0, 5'd3, 1'b1);
    ret(5'd7, 1'b1);
    #1;
    n_run++;
    if (issue_grant !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_grant got %b want 0", issue_grant);
    end
    q.push_back('{"rst_state", mk(32'h0, 3'd0, 1'b0)});
    tick();
    e = q.pop_front(); n_run++;
    if (obs !== e.v) begin
      n_fail++;
      $display("FAIL %s got %h want %h", e.nm, obs, e.v);
    end
    idle();
  endtask

  task automatic test_basic();
    iss(5'd0, 5'd0, 5'd5, 1'b1);
    #1;
    n_run++;
    if (issue_grant !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_grant got %b want 1", issue_grant);
    end
    q.push_back('{"basic_state", mk(32'h20, 3'd1, 1'b0)});
    tick();
    e = q.pop_front(); n_run++;
    if (obs !== e.v) begin
      n_fail++;
      $display("FAIL %s got %h want %h", e.nm, obs, e.v);
    end
    idle();
  endtask

  task automatic test_raw();
    iss(5'd5, 5'd0, 5'd6, 1'b1);
    #1;
    n_run++;
    if (issue_grant !== 1'b0) begin
      n_fail++;
      $display("FAIL raw_stall got %b want 0", issue_grant);
    end
    q.push_back('{"raw_hold", mk(32'h20, 3'd1, 1'b0)});
    tick();
    e = q.pop_front(); n_run++;
    if (obs !== e.v) begin
      n_fail++;
      $display("FAIL %s got %h want %h", e.nm, obs, e.v);
    end
    ret(5'd5, 1'b1);
    #1;
    n_run++;
    if (issue_grant !== 1'b0) begin
      n_fail++;
      $display("FAIL raw_no_bypass got %b want 0", issue_grant);
    end
    q.push_back('{"raw_retire", mk(32'h0, 3'd0, 1'b0)});
    tick();
    e = q.pop_front(); n_run++;
    if (obs !== e.v) begin
      n_fail++;
      $display("FAIL %s got %h want %h", e.nm, obs, e.v);
    end
    retire_valid = 1'b0;
    #1;
    n_run++;
    if (issue_grant !== 1'b1) begin
      n_fail++;
      $display("FAIL raw_release got %b want 1", issue_grant);
    end
    idle();
  endtask

  task automatic test_hazard_kinds();
    iss(5'd0, 5'd0, 5'd9, 1'b1);
    q.push_back('{"hz_set9", mk(32'h200, 3'd1, 1'b0)});
    tick();
    e = q.pop_front(); n_run++;
    if (obs !== e.v) begin
      n_fail++;
      $display("FAIL %s got %h want %h", e.nm, obs, e.v);
    end
    iss(5'd0, 5'd9, 5'd10, 1'b1);
    #1;
    n_run++;
    if (issue_grant !== 1'b0) begin
      n_fail++;
      $display("FAIL rs2_stall got %b want 0", issue_grant);
    end
    iss(5'd0, 5'd0, 5'd9, 1'b1);
    #1;
    n_run++;
    if (issue_grant !== 1'b0) begin
      n_fail++;
      $display("FAIL waw_stall got %b want 0", issue_grant);
    end
    issue_writes_rd = 1'b0;
    #1;
    n_run++;
    if (issue_grant !== 1'b1) begin
      n_fail++;
      $display("FAIL nowrite_grant got %b want 1", issue_grant);
    end
    q.push_back('{"hz_nowrite", mk(32'h200, 3'd2, 1'b0)});
    tick();
    e = q.pop_front(); n_run++;
    if (obs !== e.v) begin
      n_fail++;
      $display("FAIL %s got %h want %h", e.nm, obs, e.v);
    end
    idle();
    ret(5'd9, 1'b1);
    q.push_back('{"hz_ret9", mk(32'h0, 3'd1, 1'b0)});
    tick();
    e = q.pop_front(); n_run++;
    if (obs !== e.v) begin
      n_fail++;
      $display("FAIL %s got %h want %h", e.nm, obs, e.v);
    end
    ret(5'd9, 1'b0);
    q.push_back('{"hz_ret_nowr", mk(32'h0, 3'd0, 1'b0)});
    tick();
    e = q.pop_front(); n_run++;
    if (obs !== e.v) begin
      n_fail++;
      $display("FAIL %s got %h want %h", e.nm, obs, e.v);
    end
    idle();
  endtask

  task automatic test_full();
    logic [31:0] pm;
    pm = 32'h0;
    for (int i = 1; i <= 4; i++) begin
      iss(5'd0, 5'd0, 5'(i), 1'b1);
      pm = pm | (32'h1 << i);
      q.push_back('{"fill", mk(pm, 3'(i), 1'b0)});
      tick();
      e = q.pop_front(); n_run++;
      if (obs !== e.v) begin
        n_fail++;
        $display("FAIL %s%0d got %h want %h", e.nm, i, obs, e.v);
      end
    end
    iss(5'd0, 5'd0, 5'd5, 1'b1);
    #1;
    n_run++;
    if (issue_grant !== 1'b0) begin
      n_fail++;
      $display("FAIL full_block got %b want 0", issue_grant);
    end
    q.push_back('{"full_hold", mk(32'h1e, 3'd4, 1'b0)});
    tick();
    e = q.pop_front(); n_run++;
    if (obs !== e.v) begin
      n_fail++;
      $display("FAIL %s got %h want %h", e.nm, obs, e.v);
    end
    ret(5'd1, 1'b1);
    #1;
    n_run++;
    if (issue_grant !== 1'b0) begin
      n_fail++;
      $display("FAIL full_no_bypass got %b want 0", issue_grant);
    end
    q.push_back('{"full_ret1", mk(32'h1c, 3'd3, 1'b0)});
    tick();
    e = q.pop_front(); n_run++;
    if (obs !== e.v) begin
      n_fail++;
      $display("FAIL %s got %h want %h", e.nm, obs, e.v);
    end
    ret(5'd2, 1'b1);
    #1;
    n_run++;
    if (issue_grant !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_grant got %b want 1", issue_grant);
    end
    q.push_back('{"b2b_state", mk(32'h38, 3'd3, 1'b0)});
    tick();
    e = q.pop_front(); n_run++;
    if (obs !== e.v) begin
      n_fail++;
      $display("FAIL %s got %h want %h", e.nm, obs, e.v);
    end
    idle();
  endtask

  task automatic test_flush();
    flush = 1'b1;
    iss(5'd0, 5'd0, 5'd7, 1'b1);
    #1;
    n_run++;
    if (issue_grant !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_grant got %b want 0", issue_grant);
    end
    q.push_back('{"flush_clr", mk(32'h0, 3'd0, 1'b0)});
    tick();
    e = q.pop_front(); n_run++;
    if (obs !== e.v) begin
      n_fail++;
      $display("FAIL %s got %h want %h", e.nm, obs, e.v);
    end
    flush = 1'b0;
    iss(5'd0, 5'd0, 5'd1, 1'b1);
    q.push_back('{"fl_set1", mk(32'h2, 3'd1, 1'b0)});
    tick();
    e = q.pop_front(); n_run++;
    if (obs !== e.v) begin
      n_fail++;
      $display("FAIL %s got %h want %h", e.nm, obs, e.v);
    end
    iss(5'd0, 5'd0, 5'd2, 1'b1);
    q.push_back('{"fl_set2", mk(32'h6, 3'd2, 1'b0)});
    tick();
    e = q.pop_front(); n_run++;
    if (obs !== e.v) begin
      n_fail++;
      $display("FAIL %s got %h want %h", e.nm, obs, e.v);
    end
    idle();
    flush = 1'b1;
    ret(5'd1, 1'b1);
    q.push_back('{"flush_ret", mk(32'h0, 3'd0, 1'b0)});
    tick();
    e = q.pop_front(); n_run++;
    if (obs !== e.v) begin
      n_fail++;
      $display("FAIL %s got %h want %h", e.nm, obs, e.v);
    end
    ret(5'd7, 1'b1);
    q.push_back('{"flush_empty_ret", mk(32'h0, 3'd0, 1'b0)});
    tick();
    e = q.pop_front(); n_run++;
    if (obs !== e.v) begin
      n_fail++;
      $display("FAIL %s got %h want %h", e.nm, obs, e.v);
    end
    idle();
  endtask

  task automatic test_err();
    ret(5'd7, 1'b1);
    q.push_back('{"err_set", mk(32'h0, 3'd0, 1'b1)});
    tick();
    e = q.pop_front(); n_run++;
    if (obs !== e.v) begin
      n_fail++;
      $display("FAIL %s got %h want %h", e.nm, obs, e.v);
    end
    idle();
    q.push_back('{"err_sticky", mk(32'h0, 3'd0, 1'b1)});
    tick();
    e = q.pop_front(); n_run++;
    if (obs !== e.v) begin
      n_fail++;
      $display("FAIL %s got %h want %h", e.nm, obs, e.v);
    end
    iss(5'd0, 5'd0, 5'd3, 1'b1);
    q.push_back('{"err_issue", mk(32'h8, 3'd1, 1'b1)});
    tick();
    e = q.pop_front(); n_run++;
    if (obs !== e.v) begin
      n_fail++;
      $display("FAIL %s got %h want %h", e.nm, obs, e.v);
    end
    idle();
    rst = 1'b1;
    ret(5'd12, 1'b1);
    iss(5'd0, 5'd0, 5'd4, 1'b1);
    q.push_back('{"rst_mid", mk(32'h0, 3'd0, 1'b0)});
    tick();
    e = q.pop_front(); n_run++;
    if (obs !== e.v) begin
      n_fail++;
      $display("FAIL %s got %h want %h", e.nm, obs, e.v);
    end
    idle();
  endtask

  task automatic test_x0();
    for (int i = 0; i < 3; i++) begin
      iss(5'd0, 5'd0, 5'd0, 1'b1);
      #1;
      n_run++;
      if (issue_grant !== 1'b1) begin
        n_fail++;
        $display("FAIL x0_grant%0d got %b want 1", i, issue_grant);
      end
      q.push_back('{"x0_state", mk(32'h0, 3'(i + 1), 1'b0)});
      tick();
      e = q.pop_front(); n_run++;
      if (obs !== e.v) begin
        n_fail++;
        $display("FAIL %s%0d got %h want %h", e.nm, i, obs, e.v);
      end
    end
    idle();
    ret(5'd0, 1'b1);
    q.push_back('{"x0_retire", mk(32'h0, 3'd2, 1'b0)});
    tick();
    e = q.pop_front(); n_run++;
    if (obs !== e.v) begin
      n_fail++;
      $display("FAIL %s got %h want %h", e.nm, obs, e.v);
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_basic();
    test_raw();
    test_hazard_kinds();
    test_full();
    test_flush();
    test_err();
    test_x0();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
